// File: rtl/instr_fetch_unit.sv
// Fetch stage: credit-limited word fetches feeding an in-order {pc,instr} FIFO toward decode.
// Response reaches if_* one cycle after imem_rvalid; issue stalls once in-flight plus buffered hits DEPTH.
module instr_fetch_unit #(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_in,
  input  logic          redirect,
  output logic          pc_advance,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  output logic          if_valid,
  output logic [DW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  input  logic          id_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] LIMIT = DEPTH[CW:0];

  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_drop;

  logic [AW-1:0] r_tag [DEPTH];
  logic [PW-1:0] r_tag_wr;
  logic [PW-1:0] r_tag_rd;

  logic [AW-1:0] r_fifo_pc    [DEPTH];
  logic [DW-1:0] r_fifo_instr [DEPTH];
  logic [PW-1:0] r_fifo_wr;
  logic [PW-1:0] r_fifo_rd;

  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  logic          w_accept;
  logic [CW:0]   w_used;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp = imem_rvalid & (r_outst != '0);
  assign w_push = w_resp & (r_drop == '0) & ~redirect;
  assign w_pop  = if_valid & id_ready;

  // The head leaving this cycle frees its slot in time for this cycle's request,
  // which is what lets a 1-cycle memory stream one instruction per cycle.
  assign w_used   = {1'b0, r_outst} + {1'b0, r_cnt} - {{CW{1'b0}}, w_pop};
  assign imem_req = ~rst & ~redirect & (w_used < LIMIT);

  assign imem_addr  = pc_in;
  assign w_accept   = imem_req & imem_ready;
  assign pc_advance = w_accept;

  assign if_valid = (r_cnt != '0);
  assign if_pc    = if_valid ? r_fifo_pc[r_fifo_rd]    : '0;
  assign if_instr = if_valid ? r_fifo_instr[r_fifo_rd] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outst   <= '0;
      r_cnt     <= '0;
      r_drop    <= '0;
      r_tag_wr  <= '0;
      r_tag_rd  <= '0;
      r_fifo_wr <= '0;
      r_fifo_rd <= '0;
    end else begin
      r_outst <= r_outst + CW'(w_accept) - CW'(w_resp);
      if (w_accept) r_tag_wr <= r_tag_wr + PW'(1);
      if (w_resp)   r_tag_rd <= r_tag_rd + PW'(1);

      if (redirect) begin
        // Everything still in flight is stale; a response landing now is dropped here.
        r_drop    <= r_outst - CW'(w_resp);
        r_cnt     <= '0;
        r_fifo_rd <= r_fifo_wr;
      end else begin
        if (w_resp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        if (w_push) r_fifo_wr <= r_fifo_wr + PW'(1);
        if (w_pop)  r_fifo_rd <= r_fifo_rd + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_tag[r_tag_wr] <= pc_in;
    if (w_push) begin
      r_fifo_pc[r_fifo_wr]    <= r_tag[r_tag_rd];
      r_fifo_instr[r_fifo_wr] <= imem_rdata;
    end
  end

endmodule
